// File: rtl/lut_neuron_layer_pipe_pkg.sv
// Shared types and constants for the LUT neuron layer.
package lut_layer_pkg;

  // RUN streams data, DRAIN lets in-flight vectors leave, LOAD accepts table writes.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  // Width of the saturating accepted-output counter.
  localparam int CNT_W = 16;

endpackage

// File: rtl/lut_neuron_layer_pipe_if.sv
// Streaming, configuration and status bundle of the LUT neuron layer.
//
// Handshake rule for both streams: a transfer happens on a rising clock edge
// where valid and ready are both high. A producer holding valid keeps its
// data stable until that edge; ready never depends on valid.
interface lut_neuron_layer_pipe_if
  import lut_layer_pkg::*;
#(
  parameter int NEURONS  = 4,
  parameter int FAN_IN   = 4,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2
);
  localparam int ADDR_W = FAN_IN * IN_BITS;
  localparam int NSEL_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [NEURONS*ADDR_W-1:0]    in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NEURONS*OUT_BITS-1:0]  out_data;
  logic                         cfg_mode;
  logic                         cfg_ready;
  logic                         cfg_we;
  logic [NSEL_W-1:0]            cfg_neuron;
  logic [ADDR_W-1:0]            cfg_addr;
  logic [OUT_BITS-1:0]          cfg_data;
  logic [CNT_W-1:0]             out_count;

  modport master (
    output in_valid, in_data, out_ready,
    output cfg_mode, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_ready, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    input  cfg_mode, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_ready, out_count
  );

endinterface

// File: rtl/lut_neuron_layer_pipe_table.sv
// One neuron's truth table: distributed RAM with a registered read port.
// Contents are never reset so programmed tables survive rst; only the read
// register is cleared, which gives a defined zero output after reset.
module lut_neuron_table #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_en,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Table write; no reset so configuration persists across rst.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered lookup; holds its value while i_en is low (output stall).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_en) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lut_neuron_layer_pipe.sv
// Two-stage pipelined layer of LUT neurons with runtime-loadable tables.
// S1 captures the input vector, S2 is the registered table lookup that
// drives out_data. Table loads are only possible once the pipe has drained.
module lut_neuron_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int NEURONS  = 4,
  parameter int FAN_IN   = 4,
  parameter int IN_BITS  = 2,
  parameter int OUT_BITS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  lut_neuron_layer_pipe_if.slave bus,
  output state_t                 o_state
);
  localparam int ADDR_W = FAN_IN * IN_BITS;
  localparam int NSEL_W = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic                        r_s1_v;
  logic [NEURONS*ADDR_W-1:0]   r_s1_data;
  logic                        r_out_valid;
  logic [CNT_W-1:0]            r_out_count;
  logic [NEURONS*OUT_BITS-1:0] w_out_data;
  logic                        w_s1_adv;
  logic                        w_in_hs;
  logic                        w_out_hs;

  // S1 moves into S2 when S2 is empty or being consumed this cycle.
  assign w_s1_adv      = r_s1_v & (~r_out_valid | bus.out_ready);
  assign bus.in_ready  = (r_state == ST_RUN) & (~r_s1_v | w_s1_adv);
  assign w_in_hs       = bus.in_valid & bus.in_ready;
  assign w_out_hs      = r_out_valid & bus.out_ready;
  assign bus.cfg_ready = (r_state == ST_LOAD);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.out_count = r_out_count;
  assign o_state       = r_state;

  // Mode FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Mode FSM next state: DRAIN aborts back to RUN if cfg_mode drops early.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:   if (bus.cfg_mode) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!bus.cfg_mode)                 w_state_nxt = ST_RUN;
        else if (!r_s1_v && !r_out_valid)  w_state_nxt = ST_LOAD;
      end
      ST_LOAD:  if (!bus.cfg_mode) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  // S1 valid: set on input handshake, cleared when S1 moves on without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_s1_v <= 1'b0;
    else if (w_in_hs)  r_s1_v <= 1'b1;
    else if (w_s1_adv) r_s1_v <= 1'b0;
  end

  // S1 data: captured only on input handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_s1_data <= '0;
    else if (w_in_hs) r_s1_data <= bus.in_data;
  end

  // S2 valid: reload on advance takes priority over consume (no bubble).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_out_valid <= 1'b0;
    else if (w_s1_adv) r_out_valid <= 1'b1;
    else if (w_out_hs) r_out_valid <= 1'b0;
  end

  // Saturating count of accepted output vectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                        r_out_count <= '0;
    else if (w_out_hs && (r_out_count != '1))       r_out_count <= r_out_count + 1'b1;
  end

  // One table per neuron; out-of-range neuron selects match no table.
  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    logic w_we;
    assign w_we = bus.cfg_ready & bus.cfg_we & (bus.cfg_neuron == NSEL_W'(n));

    lut_neuron_table #(
      .ADDR_W (ADDR_W),
      .DATA_W (OUT_BITS)
    ) u_table (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_waddr (bus.cfg_addr),
      .i_wdata (bus.cfg_data),
      .i_en    (w_s1_adv),
      .i_raddr (r_s1_data[n*ADDR_W +: ADDR_W]),
      .o_rdata (w_out_data[n*OUT_BITS +: OUT_BITS])
    );
  end

endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// Self-checking bench for lut_neuron_layer_pipe: table model plus an
// expected-output queue filled at input handshakes, drained at output handshakes.
module tb_lut_neuron_layer_pipe;
  import lut_layer_pkg::*;

  localparam int NEURONS  = 4;
  localparam int FAN_IN   = 4;
  localparam int IN_BITS  = 2;
  localparam int OUT_BITS = 2;
  localparam int ADDR_W   = FAN_IN * IN_BITS;
  localparam int VEC_W    = NEURONS * ADDR_W;
  localparam int OUT_W    = NEURONS * OUT_BITS;

  logic clk = 1'b0;
  logic rst;
  state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OUT_W-1:0]    exp_q[$];
  logic [OUT_BITS-1:0] tbl [NEURONS][2**ADDR_W];
  logic                hold_prev;
  logic [OUT_W-1:0]    hold_data;

  lut_neuron_layer_pipe_if #(
    .NEURONS(NEURONS), .FAN_IN(FAN_IN), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)
  ) bus ();

  lut_neuron_layer_pipe #(
    .NEURONS(NEURONS), .FAN_IN(FAN_IN), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] model(input logic [VEC_W-1:0] v);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int n = 0; n < NEURONS; n++)
      r[n*OUT_BITS +: OUT_BITS] = tbl[n][v[n*ADDR_W +: ADDR_W]];
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, hold_data);
      end
      if (bus.cfg_ready && bus.cfg_we && (int'(bus.cfg_neuron) < NEURONS))
        tbl[bus.cfg_neuron][bus.cfg_addr] = bus.cfg_data;
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_data));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else                   check("sb_data", bus.out_data, exp_q.pop_front());
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      hold_data = bus.out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic enter_load();
    int k = 0;
    bus.cfg_mode = 1'b1;
    while (!bus.cfg_ready && k < 50) begin
      tick();
      k++;
    end
    check("enter_load", bus.cfg_ready, 1);
  endtask

  task automatic cfg_write(input int n, input logic [ADDR_W-1:0] a, input logic [OUT_BITS-1:0] d);
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = n[1:0];
    bus.cfg_addr   = a;
    bus.cfg_data   = d;
    tick();
    bus.cfg_we     = 1'b0;
  endtask

  task automatic send(input logic [VEC_W-1:0] v);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    while (!bus.in_ready && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) check("send_timeout", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    bus.out_ready = 1'b1;
    while ((bus.out_valid || exp_q.size() != 0) && k < 50) begin
      tick();
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [VEC_W-1:0]  v [3];
    logic [ADDR_W-1:0] a;
    logic [OUT_BITS-1:0] d;
    int acc;
    int k;
    logic hs;

    rst = 1'b1;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    bus.cfg_mode = 0; bus.cfg_we = 0; bus.cfg_neuron = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_out_count", bus.out_count, 0);
    check("rst_state", dbg_state, ST_RUN);
    @(negedge clk);
    #2 rst = 1'b0;
    tick();

    // Program every table entry so the model is fully defined.
    bus.out_ready = 1'b1;
    enter_load();
    for (int n = 0; n < NEURONS; n++) begin
      for (int i = 0; i < 2**ADDR_W; i++) begin
        a = ADDR_W'(i);
        case (n)
          0:       d = a[1:0];
          1:       d = a[7:6];
          2:       d = a[3:2] ^ a[5:4];
          default: d = OUT_BITS'($urandom_range(0, 3));
        endcase
        cfg_write(n, a, d);
      end
    end
    bus.cfg_mode = 1'b0;
    tick();
    check("prog_state_run", dbg_state, ST_RUN);
    check("prog_cfg_ready", bus.cfg_ready, 0);

    // Directed lookup and two-cycle latency.
    bus.in_valid = 1'b1;
    bus.in_data  = {8'h00, 8'h00, 8'h3A, 8'hC5};
    check("t1_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("t1_lat1_valid", bus.out_valid, 0);
    tick();
    check("t1_lat2_valid", bus.out_valid, 1);
    check("t1_n0", bus.out_data[1:0], 2'b01);
    check("t1_n1", bus.out_data[3:2], 2'b00);
    tick();

    // Back-to-back stream from a freshly reset counter.
    pulse_reset();
    check("b2b_cnt0", bus.out_count, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom();
      check("b2b_in_ready", bus.in_ready, 1);
      if (i >= 2) check("b2b_out_valid", bus.out_valid, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("b2b_count", bus.out_count, 100);

    // Backpressure: 3 vectors offered over 5 stalled cycles.
    for (int i = 0; i < 3; i++) v[i] = $urandom();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = v[0];
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      hs = bus.in_ready;
      tick();
      if (hs && acc < 3) begin
        acc++;
        if (acc < 3) bus.in_data = v[acc];
      end
    end
    check("bp_accepted", acc, 2);
    check("bp_in_ready", bus.in_ready, 0);
    bus.out_ready = 1'b1;
    send(v[2]);
    drain();

    // Mode switch with two vectors in flight.
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom();
    tick();
    bus.in_data  = $urandom();
    bus.cfg_mode = 1'b1;
    check("mode_second_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("mode_in_ready", bus.in_ready, 0);
    check("mode_state_drain", dbg_state, ST_DRAIN);
    k = 0;
    while (!bus.cfg_ready && k < 20) begin
      tick();
      k++;
    end
    check("mode_cfg_ready", bus.cfg_ready, 1);
    check("mode_load_lat", k, 3);
    check("mode_out_valid", bus.out_valid, 0);
    check("mode_sb_empty", exp_q.size(), 0);

    // Load one entry, then try a write in RUN that must be ignored.
    cfg_write(2, 8'h00, 2'b11);
    bus.cfg_mode = 1'b0;
    tick();
    check("load_exit_run", dbg_state, ST_RUN);
    cfg_write(2, 8'h00, 2'b01);
    send('0);
    tick();
    check("load_out_valid", bus.out_valid, 1);
    check("load_n2", bus.out_data[5:4], 2'b11);
    drain();

    // Asynchronous reset with a held output and count of 7.
    pulse_reset();
    for (int i = 0; i < 7; i++) send($urandom());
    drain();
    check("rst7_count", bus.out_count, 7);
    bus.out_ready = 1'b0;
    send($urandom());
    tick();
    check("rst7_out_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_count", bus.out_count, 0);
    check("arst_state", dbg_state, ST_RUN);
    check("arst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    // Tables survive reset.
    send({8'h00, 8'h00, 8'h3A, 8'hC5});
    tick();
    check("post_rst_valid", bus.out_valid, 1);
    check("post_rst_n0", bus.out_data[1:0], 2'b01);
    check("post_rst_n1", bus.out_data[3:2], 2'b00);
    check("post_rst_n2", bus.out_data[5:4], 2'b11);
    for (int i = 0; i < 20; i++) send($urandom());
    drain();

    check("final_sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
